alu_cmd_master: RTL and testbench

//  Initiator side of the ALU operand/result handshake. Accepts one command
//  (opcode + two operands) on a valid/ready upstream port and serializes it

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_watchdog.sv | 37 +++
 rtl/alu_cmd_master.sv | 179 +++++++++++++++++
 tb/tb_alu_cmd_master.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command path.
//   DEFAULT_WIDTH     default operand/result width
//   OP_ADD..OP_DIV    two-bit opcodes understood by the ALU
//   ST_*              alu_cmd_master FSM state encodings
package alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned OP_W          = 2;
  localparam int unsigned STATE_W       = 3;

  typedef logic [OP_W-1:0] alu_op_t;

  localparam alu_op_t OP_ADD = 2'b00;
  localparam alu_op_t OP_SUB = 2'b01;
  localparam alu_op_t OP_MUL = 2'b10;
  localparam alu_op_t OP_DIV = 2'b11;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SEND_A = 3'd1;
  localparam logic [2:0] ST_SEND_B = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

endpackage

// File: rtl/alu_watchdog.sv
// WAIT-state timeout counter for alu_cmd_master.
// Only compiled when ALU_TIMEOUT_EN is defined.
//   clk, rst   clock and synchronous active-high reset
//   clr        clears the count (asserted the cycle before WAIT is entered)
//   en         counting enable (high while in WAIT)
//   expired_c  high during the TIMEOUT_CYCLES-th consecutive WAIT cycle
`ifdef ALU_TIMEOUT_EN
module alu_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  // Counts 0..TIMEOUT_CYCLES-1, so the width depends only on the timeout.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign expired_c = en && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Saturates at the expiry value; the FSM leaves WAIT on expiry anyway.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/alu_cmd_master.sv
// Initiator side of the ALU operand/result handshake. Takes one command on a
// valid/ready port, sends operand A then B to the ALU as one-cycle strobes,
// waits for alu_ready, and returns the captured result on a valid/ready
// response port. One transaction in flight at a time.
// Optional feature macro: ALU_TIMEOUT_EN (WAIT timeout with rsp_err).
//   clk, rst                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_op, cmd_a, cmd_b         opcode and operands
//   alu_in, alu_op, alu_valid    operand beats to the ALU
//   alu_o, alu_ready             ALU result and its valid
//   rsp_valid/rsp_ready          response handshake
//   rsp_data, rsp_err            captured result, timeout flag
//   busy                         high whenever not IDLE
module alu_cmd_master
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
`ifdef ALU_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [WIDTH-1:0]  cmd_a,
  input  logic [WIDTH-1:0]  cmd_b,
  output logic [WIDTH-1:0]  alu_in,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_valid,
  input  logic [WIDTH-1:0]  alu_o,
  input  logic              alu_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              rsp_err,
  output logic              busy
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [WIDTH-1:0]   b_q, b_d;

  logic               cmd_ready_d;
  logic [WIDTH-1:0]   alu_in_d;
  logic [OP_W-1:0]    alu_op_d;
  logic               alu_valid_d;
  logic               rsp_valid_d;
  logic [WIDTH-1:0]   rsp_data_d;
  logic               busy_d;

`ifdef ALU_TIMEOUT_EN
  logic rsp_err_d;
  logic expired_c;

  // Cleared in SEND_B so the count starts at zero on the first WAIT cycle.
  alu_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_q == ST_SEND_B),
    .en        (state_q == ST_WAIT),
    .expired_c (expired_c)
  );
`else
  assign rsp_err = 1'b0;
`endif

  // Next state and next registered output values. Outputs are computed for
  // the state being entered, so they line up with the state register.
  always_comb begin
    state_d     = state_q;
    b_d         = b_q;
    cmd_ready_d = cmd_ready;
    alu_in_d    = alu_in;
    alu_op_d    = alu_op;
    alu_valid_d = 1'b0;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;
    busy_d      = busy;
`ifdef ALU_TIMEOUT_EN
    rsp_err_d   = rsp_err;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d     = ST_SEND_A;
          b_d         = cmd_b;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          alu_valid_d = 1'b1;
          alu_in_d    = cmd_a;
          alu_op_d    = cmd_op;
        end
      end

      ST_SEND_A: begin
        state_d     = ST_SEND_B;
        alu_valid_d = 1'b1;
        alu_in_d    = b_q;
      end

      ST_SEND_B: begin
        state_d = ST_WAIT;
      end

      // A ready coinciding with expiry takes priority over the timeout.
      ST_WAIT: begin
        if (alu_ready) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = alu_o;
`ifdef ALU_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (expired_c) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
`endif
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
`ifdef ALU_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
        end
      end

      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      b_q       <= '0;
      cmd_ready <= 1'b1;
      alu_in    <= '0;
      alu_op    <= '0;
      alu_valid <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
`ifdef ALU_TIMEOUT_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      b_q       <= b_d;
      cmd_ready <= cmd_ready_d;
      alu_in    <= alu_in_d;
      alu_op    <= alu_op_d;
      alu_valid <= alu_valid_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      busy      <= busy_d;
`ifdef ALU_TIMEOUT_EN
      rsp_err   <= rsp_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_cmd_master.sv
// Self-checking bench for alu_cmd_master with a behavioural ALU stub.
// Optional macro: ALU_TIMEOUT_EN (adds the timeout scenarios).
module tb_alu_cmd_master;
  import alu_pkg::*;

  localparam int unsigned W = 8;
`ifdef ALU_TIMEOUT_EN
  localparam int unsigned TO = 255;
`endif

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic [W-1:0] alu_in;
  logic [1:0]   alu_op;
  logic         alu_valid;
  logic [W-1:0] alu_o;
  logic         alu_ready;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_err;
  logic         busy;

  int checks = 0;
  int errors = 0;

  alu_cmd_master #(
    .WIDTH          (W)
`ifdef ALU_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (TO)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .alu_in    (alu_in),
    .alu_op    (alu_op),
    .alu_valid (alu_valid),
    .alu_o     (alu_o),
    .alu_ready (alu_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU arithmetic as seen by the bench; divide by zero yields all ones.
  function automatic logic [W-1:0] ref_alu(input logic [1:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int unsigned r;
    case (op)
      2'b00:   r = 32'(a) + 32'(b);
      2'b01:   r = 32'(a) - 32'(b);
      2'b10:   r = 32'(a) * 32'(b);
      default: r = (b == '0) ? 32'hFFFF_FFFF : 32'(a) / 32'(b);
    endcase
    return W'(r);
  endfunction

  // ALU stub: two operand beats, result ready alu_lat cycles after beat B.
  logic         model_ready;
  logic         stale_ready;
  logic [W-1:0] model_o;
  int           alu_lat;
  bit           alu_dead;
  logic [W-1:0] stub_a;
  bit           stub_beat;
  bit           stub_pend;
  int           stub_cnt;

  assign alu_ready = model_ready | stale_ready;
  assign alu_o     = model_o;

  always @(posedge clk) begin
    if (rst) begin
      stub_beat   = 1'b0;
      stub_pend   = 1'b0;
      model_ready <= 1'b0;
      model_o     <= '0;
    end else begin
      model_ready <= 1'b0;
      if (stub_pend) begin
        if (stub_cnt == 0) begin
          model_ready <= 1'b1;
          stub_pend = 1'b0;
        end else begin
          stub_cnt--;
        end
      end
      if (alu_valid) begin
        if (!stub_beat) begin
          stub_a    = alu_in;
          stub_beat = 1'b1;
        end else begin
          model_o   <= ref_alu(alu_op, stub_a, alu_in);
          stub_beat = 1'b0;
          if (!alu_dead) begin
            if (alu_lat == 0) begin
              model_ready <= 1'b1;
            end else begin
              stub_pend = 1'b1;
              stub_cnt  = alu_lat - 1;
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with timing checks; cycle 0 is the handshake cycle.
  task automatic run_txn(input string tag, input logic [1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input int lat, input bit dead, input int bp, input bit stale,
                         input logic [W-1:0] exp_data, input bit exp_err, input int exp_lat);
    int cyc;
    alu_lat   = lat;
    alu_dead  = dead;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    check({tag, " cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    cmd_a     = ~a;
    cmd_b     = ~b;
    if (stale) stale_ready = 1'b1;
    check({tag, " send_a_valid"}, 32'(alu_valid), 32'd1);
    check({tag, " send_a_in"}, 32'(alu_in), 32'(a));
    check({tag, " send_a_op"}, 32'(alu_op), 32'(op));
    check({tag, " cmd_ready_busy"}, 32'(cmd_ready), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd1);
    step();
    check({tag, " send_b_valid"}, 32'(alu_valid), 32'd1);
    check({tag, " send_b_in"}, 32'(alu_in), 32'(b));
    check({tag, " send_b_op"}, 32'(alu_op), 32'(op));
    step();
    stale_ready = 1'b0;
    check({tag, " wait_valid"}, 32'(alu_valid), 32'd0);
    check({tag, " wait_op"}, 32'(alu_op), 32'(op));
    cyc = 3;
    while (!rsp_valid && cyc < exp_lat + 20) begin
      check({tag, " cmd_ready_wait"}, 32'(cmd_ready), 32'd0);
      step();
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, " rsp_data"}, 32'(rsp_data), 32'(exp_data));
    check({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
    for (int i = 0; i < bp; i++) begin
      cmd_valid = 1'b1;
      step();
      check({tag, " bp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, " bp_data"}, 32'(rsp_data), 32'(exp_data));
      check({tag, " bp_cmd_ready"}, 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, " done_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " done_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, " done_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, " alu_valid"}, 32'(alu_valid), 32'd0);
    check({tag, " alu_in"}, 32'(alu_in), 32'd0);
    check({tag, " alu_op"}, 32'(alu_op), 32'd0);
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " rsp_data"}, 32'(rsp_data), 32'd0);
    check({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           lat;
    int           bp;
    bit           stale;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{2'b00, 8'd5,   8'd3,   0, 0, 1'b0, 8'd8};
    vecs[1] = '{2'b01, 8'd10,  8'd4,   0, 0, 1'b0, 8'd6};
    vecs[2] = '{2'b10, 8'd3,   8'd7,   0, 0, 1'b0, 8'd21};
    vecs[3] = '{2'b11, 8'd15,  8'd3,   0, 0, 1'b0, 8'd5};
    vecs[4] = '{2'b00, 8'd200, 8'd100, 2, 5, 1'b0, 8'd44};
    vecs[5] = '{2'b01, 8'd3,   8'd5,   1, 0, 1'b1, 8'd254};
    vecs[6] = '{2'b10, 8'd16,  8'd16,  0, 1, 1'b0, 8'd0};
    vecs[7] = '{2'b11, 8'd9,   8'd0,   0, 0, 1'b1, 8'd255};

    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_op      = '0;
    cmd_a       = '0;
    cmd_b       = '0;
    rsp_ready   = 1'b0;
    stale_ready = 1'b0;
    alu_lat     = 0;
    alu_dead    = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check_reset_values("reset");

    // rsp_ready with nothing pending is a no-op.
    rsp_ready = 1'b1;
    repeat (3) begin
      step();
      check("idle_rsp_ready rsp_valid", 32'(rsp_valid), 32'd0);
      check("idle_rsp_ready cmd_ready", 32'(cmd_ready), 32'd1);
    end
    rsp_ready = 1'b0;

    foreach (vecs[i])
      run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
              vecs[i].lat, 1'b0, vecs[i].bp, vecs[i].stale,
              vecs[i].exp, 1'b0, 4 + vecs[i].lat);

    // Reset while waiting on the ALU: command dropped, no response.
    alu_lat   = 2;
    alu_dead  = 1'b0;
    cmd_op    = 2'b00;
    cmd_a     = 8'd1;
    cmd_b     = 8'd2;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    check("rst_wait busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_values("rst_wait");
    repeat (8) begin
      step();
      check("rst_wait no_rsp", 32'(rsp_valid), 32'd0);
    end

    for (int n = 0; n < 30; n++) begin
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           lat;
      op  = 2'($urandom_range(0, 3));
      a   = W'($urandom);
      b   = W'($urandom);
      lat = int'($urandom_range(0, 3));
      run_txn($sformatf("rnd%0d", n), op, a, b, lat, 1'b0,
              int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
              ref_alu(op, a, b), 1'b0, 4 + lat);
    end

`ifdef ALU_TIMEOUT_EN
    run_txn("timeout", 2'b00, 8'd7, 8'd9, 0, 1'b1, 2, 1'b0, 8'd0, 1'b1, 3 + TO);
    run_txn("ready_at_expiry", 2'b10, 8'd6, 8'd7, TO - 1, 1'b0, 0, 1'b0, 8'd42, 1'b0, 3 + TO);
    run_txn("ready_after_expiry", 2'b01, 8'd9, 8'd2, TO, 1'b0, 0, 1'b0, 8'd0, 1'b1, 3 + TO);
    repeat (3) step();
    run_txn("post_timeout", 2'b00, 8'd5, 8'd3, 0, 1'b0, 0, 1'b0, 8'd8, 1'b0, 4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish within 1 ms");
    $fatal(1);
  end

endmodule
